mips_ctrl_decode_ex: RTL and testbench

- Decode-stage control unit for the pipelined MIPS core, plus the ID/EX control pipeline register.
- Decodes opcode/funct into the EX/MEM/WB control word, including the 3-bit ALUControl consumed by the ALU in EX.
- Owns the multi-cycle-multiply interlock: holds a MUL in EX for extra cycles and stalls Fetch/Decode meanwhile.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/mips_main_dec.sv | 72 +++++++
 rtl/mips_ctrl_decode_ex.sv | 80 ++++++++
 tb/tb_mips_ctrl_decode_ex.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU operation codes, opcodes, funct codes and the
// EX-stage control word carried through the ID/EX register.
package mips_pkg;

    // ALUControl encodings (011 and 111 are unused)
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // Opcodes, instruction [31:26]
    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_J        = 6'b000010;

    // Funct codes, instruction [5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b000010;

    // Control word consumed by EX/MEM/WB
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    // Bubble: no side effects, ALUControl 000
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_main_dec.sv
// Combinational table decode of opcode/funct into the EX control word,
// plus the D-stage branch/jump flags and a MUL marker for the hold logic.
module mips_main_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       branch,
    output logic       jump,
    output logic       is_mul
);

    // Table decode; anything not listed falls through to the illegal word
    always_comb begin
        ctrl             = CTRL_BUBBLE;
        ctrl.alu_control = ALU_ADD;
        branch           = 1'b0;
        jump             = 1'b0;
        is_mul           = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    default: begin
                        ctrl             = CTRL_BUBBLE;
                        ctrl.alu_control = ALU_ADD;
                        ctrl.illegal     = 1'b1;
                    end
                endcase
            end
            OP_SPECIAL2: begin
                if (funct == FN_MUL) begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.reg_dst     = 1'b1;
                    ctrl.alu_control = ALU_MUL;
                    is_mul           = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_control = ALU_SUB;
                branch           = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_decode_ex.sv
// Decode-stage control unit with the ID/EX control register and the
// multi-cycle MUL interlock (holds EX, stalls F/D while the counter runs).
module mips_ctrl_decode_ex
    import mips_pkg::*;
#(
    parameter int MUL_EXTRA = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OpD,
    input  logic [5:0] FunctD,
    input  logic       FlushE,
    output logic       RegWriteE,
    output logic       MemtoRegE,
    output logic       MemWriteE,
    output logic       ALUSrcE,
    output logic       RegDstE,
    output logic [2:0] ALUControlE,
    output logic       IllegalE,
    output logic       BranchD,
    output logic       JumpD,
    output logic       MulStallD
);

    localparam int CNT_W = (MUL_EXTRA > 0) ? $clog2(MUL_EXTRA + 1) : 1;

    ctrl_t            dec_d;
    ctrl_t            ex_q;
    logic             is_mul_d;
    logic [CNT_W-1:0] cnt;

    mips_main_dec u_dec (
        .op     (OpD),
        .funct  (FunctD),
        .ctrl   (dec_d),
        .branch (BranchD),
        .jump   (JumpD),
        .is_mul (is_mul_d)
    );

    generate
        if (MUL_EXTRA > 0) begin : g_hold
            // Hold counter: armed when a MUL enters EX, counts down while held
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST)
                    cnt <= '0;
                else if (cnt != '0)
                    cnt <= cnt - CNT_W'(1);
                else if (!FlushE && is_mul_d)
                    cnt <= CNT_W'(MUL_EXTRA);
            end
        end else begin : g_no_hold
            assign cnt = '0;
        end
    endgenerate

    // Stall depends only on the counter, never on the D-stage inputs
    assign MulStallD = (cnt != '0);

    // ID/EX register: hold beats flush, flush beats a fresh decode
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            ex_q <= CTRL_BUBBLE;
        else if (cnt != '0)
            ex_q <= ex_q;
        else if (FlushE)
            ex_q <= CTRL_BUBBLE;
        else
            ex_q <= dec_d;
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemtoRegE   = ex_q.mem_to_reg;
    assign MemWriteE   = ex_q.mem_write;
    assign ALUSrcE     = ex_q.alu_src;
    assign RegDstE     = ex_q.reg_dst;
    assign ALUControlE = ex_q.alu_control;
    assign IllegalE    = ex_q.illegal;

endmodule

// File: tb/tb_mips_ctrl_decode_ex.sv
// Scoreboard bench: the driver pushes hand-computed expectations per cycle,
// the monitor pops and compares on each falling edge.
module tb_mips_ctrl_decode_ex;

    // Expected EX word: {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl,Illegal}
    localparam logic [8:0] E_ADD  = 9'b10001_010_0;
    localparam logic [8:0] E_SUB  = 9'b10001_100_0;
    localparam logic [8:0] E_AND  = 9'b10001_000_0;
    localparam logic [8:0] E_OR   = 9'b10001_001_0;
    localparam logic [8:0] E_SLT  = 9'b10001_110_0;
    localparam logic [8:0] E_MUL  = 9'b10001_101_0;
    localparam logic [8:0] E_LW   = 9'b11010_010_0;
    localparam logic [8:0] E_SW   = 9'b00110_010_0;
    localparam logic [8:0] E_ADDI = 9'b10010_010_0;
    localparam logic [8:0] E_BEQ  = 9'b00000_100_0;
    localparam logic [8:0] E_J    = 9'b00000_010_0;
    localparam logic [8:0] E_ILL  = 9'b00000_010_1;
    localparam logic [8:0] E_BUB  = 9'b00000_000_0;

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] S2 = 6'b011100;

    typedef struct {
        int         row;
        logic [8:0] ew;
        logic       stall;
        logic       br;
        logic       jp;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] OpD = 6'b0;
    logic [5:0] FunctD = 6'b0;
    logic       FlushE = 1'b0;

    logic       RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, IllegalE;
    logic [2:0] ALUControlE;
    logic       BranchD, JumpD, MulStallD;
    logic       RegWriteE0, MemtoRegE0, MemWriteE0, ALUSrcE0, RegDstE0, IllegalE0;
    logic [2:0] ALUControlE0;
    logic       BranchD0, JumpD0, MulStallD0;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   row = 0;

    always #5 CLK = ~CLK;

    mips_ctrl_decode_ex #(.MUL_EXTRA(2)) dut (
        .CLK(CLK), .RST(RST), .OpD(OpD), .FunctD(FunctD), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .IllegalE(IllegalE), .BranchD(BranchD), .JumpD(JumpD), .MulStallD(MulStallD)
    );

    mips_ctrl_decode_ex #(.MUL_EXTRA(0)) dut0 (
        .CLK(CLK), .RST(RST), .OpD(OpD), .FunctD(FunctD), .FlushE(FlushE),
        .RegWriteE(RegWriteE0), .MemtoRegE(MemtoRegE0), .MemWriteE(MemWriteE0),
        .ALUSrcE(ALUSrcE0), .RegDstE(RegDstE0), .ALUControlE(ALUControlE0),
        .IllegalE(IllegalE0), .BranchD(BranchD0), .JumpD(JumpD0), .MulStallD(MulStallD0)
    );

    wire [8:0] ew_act = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
                         ALUControlE, IllegalE};
    wire [8:0] ew_act0 = {RegWriteE0, MemtoRegE0, MemWriteE0, ALUSrcE0, RegDstE0,
                          ALUControlE0, IllegalE0};

    task automatic chk(input string name, input int r, input logic [8:0] got,
                       input logic [8:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s row %0d: got %b expected %b", name, r, got, want);
    endtask

    // Drive one D-stage instruction after the edge and queue what the
    // outputs must show before the next edge
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic fl,
                        input logic [8:0] ew, input logic st, input logic b,
                        input logic j);
        exp_t e;
        @(posedge CLK);
        #1;
        OpD = op;
        FunctD = fn;
        FlushE = fl;
        e.row = row;
        e.ew = ew;
        e.stall = st;
        e.br = b;
        e.jp = j;
        exp_q.push_back(e);
        row++;
    endtask

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ex_word", e.row, ew_act, e.ew);
            chk("mul_stall", e.row, {8'b0, MulStallD}, {8'b0, e.stall});
            chk("branch_jump", e.row, {7'b0, BranchD, JumpD}, {7'b0, e.br, e.jp});
            chk("stall_extra0", e.row, {8'b0, MulStallD0}, 9'b0);
        end
    end

    initial begin
        // Power-up reset, checked without a clock edge
        #1 RST = 1'b0;
        #1;
        chk("reset_word", -1, ew_act, E_BUB);
        chk("reset_stall", -1, {8'b0, MulStallD}, 9'b0);
        OpD = R; FunctD = 6'b100000;
        #6 RST = 1'b1;

        // Decode sweep (ADD loaded at the first edge after reset)
        step(6'b100011, 6'b0, 0, E_ADD, 0, 0, 0);   // lw
        step(6'b101011, 6'b0, 0, E_LW, 0, 0, 0);    // sw
        step(6'b001000, 6'b0, 0, E_SW, 0, 0, 0);    // addi
        step(6'b000100, 6'b0, 0, E_ADDI, 0, 1, 0);  // beq
        step(6'b000010, 6'b0, 0, E_BEQ, 0, 0, 1);   // j
        step(R, 6'b100010, 0, E_J, 0, 0, 0);        // sub
        step(R, 6'b100100, 0, E_SUB, 0, 0, 0);      // and
        step(R, 6'b100101, 0, E_AND, 0, 0, 0);      // or
        step(R, 6'b101010, 0, E_OR, 0, 0, 0);       // slt
        // Illegal encodings, then a legal one clears IllegalE
        step(6'b111111, 6'b0, 0, E_SLT, 0, 0, 0);
        step(R, 6'b000000, 0, E_ILL, 0, 0, 0);
        step(S2, 6'b000000, 0, E_ILL, 0, 0, 0);
        step(R, 6'b100000, 0, E_ILL, 0, 0, 0);
        // MUL then ADD: MUL in EX for 3 cycles, stall for the first two
        step(S2, 6'b000010, 0, E_ADD, 0, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 1, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 1, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 0, 0, 0);
        // Flush with no hold -> bubble
        step(R, 6'b100000, 1, E_ADD, 0, 0, 0);
        step(S2, 6'b000010, 0, E_BUB, 0, 0, 0);
        // Flush during hold is ignored; then back-to-back MUL
        step(R, 6'b100000, 1, E_MUL, 1, 0, 0);
        step(R, 6'b100000, 1, E_MUL, 1, 0, 0);
        step(S2, 6'b000010, 0, E_MUL, 0, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 1, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 1, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 0, 0, 0);
        step(6'b000010, 6'b0, 0, E_ADD, 0, 0, 1);
        step(6'b000100, 6'b0, 0, E_J, 0, 1, 0);
        // Branch/jump flags still decode while stalled
        step(S2, 6'b000010, 0, E_BEQ, 0, 0, 0);
        step(6'b000100, 6'b0, 0, E_MUL, 1, 1, 0);
        step(6'b000010, 6'b0, 0, E_MUL, 1, 0, 1);
        step(R, 6'b100000, 0, E_MUL, 0, 0, 0);
        step(R, 6'b100000, 0, E_ADD, 0, 0, 0);
        // Reset in the middle of a MUL hold
        step(S2, 6'b000010, 0, E_ADD, 0, 0, 0);
        step(R, 6'b100000, 0, E_MUL, 1, 0, 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("async_reset_word", row, ew_act, E_BUB);
        chk("async_reset_stall", row, {8'b0, MulStallD}, 9'b0);
        chk("async_reset_word0", row, ew_act0, E_BUB);
        @(posedge CLK);
        #1;
        chk("held_reset_word", row, ew_act, E_BUB);
        OpD = R; FunctD = 6'b100000; FlushE = 1'b0;
        #2 RST = 1'b1;
        step(6'b101011, 6'b0, 0, E_ADD, 0, 0, 0);
        step(R, 6'b100000, 0, E_SW, 0, 0, 0);

        repeat (2) @(negedge CLK);
        #1;
        chk("queue_drained", row, 9'(exp_q.size()), 9'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
